// File: rtl/counter_pkg.sv
// Shared types for the programmable up/down counter: run modes, the
// one-shot state encoding and a mode decode helper.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } cnt_mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } cnt_state_e;

    // Raw 2-bit mode field to run mode; the unused code 2'b11 behaves as wrap.
    function automatic cnt_mode_e decode_mode(input logic [1:0] raw);
        cnt_mode_e m;
        case (raw)
            2'b00:   m = MODE_WRAP;
            2'b01:   m = MODE_SAT;
            2'b10:   m = MODE_ONESHOT;
            default: m = MODE_WRAP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/counter_ud_next.sv
// Combinational next-count calculation for one enabled step: handles the
// zero step, a stale count above the limit, and the in-range up/down cases
// for wrap, saturate and one-shot modes. Also flags a wrap event and a
// one-shot terminal hit.
module counter_ud_next
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH:0]   step_eff,
    input  logic [WIDTH-1:0] limit,
    input  logic             down,
    input  cnt_mode_e        mode,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_hit,
    output logic             term_hit
);

    localparam logic [WIDTH:0]   ZERO_X = {(WIDTH + 1){1'b0}};
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH - 1){1'b0}}, 1'b1};

    logic [WIDTH:0]   cnt_x_s;
    logic [WIDTH:0]   lim_x_s;
    logic [WIDTH:0]   up_sum_s;
    logic [WIDTH-1:0] up_wrap_s;
    logic [WIDTH-1:0] dn_diff_s;
    logic [WIDTH-1:0] dn_wrap_s;

    // Decisions use the exact WIDTH+1 sum; the wrapped and difference
    // results always land inside 0..limit, so WIDTH-bit arithmetic on them
    // is exact.
    assign cnt_x_s   = {1'b0, count};
    assign lim_x_s   = {1'b0, limit};
    assign up_sum_s  = cnt_x_s + step_eff;
    assign up_wrap_s = up_sum_s[WIDTH-1:0] - limit - ONE_W;
    assign dn_diff_s = count - step_eff[WIDTH-1:0];
    assign dn_wrap_s = count + limit + ONE_W - step_eff[WIDTH-1:0];

    // Select the stepped count and the wrap / terminal flags for this cycle.
    always_comb begin
        next_count = count;
        wrap_hit   = 1'b0;
        term_hit   = 1'b0;
        if (step_eff == ZERO_X) begin
            next_count = count;
        end else if (cnt_x_s > lim_x_s) begin
            // Limit was lowered below the current count: pull back into range.
            case (mode)
                MODE_WRAP:    next_count = ZERO_W;
                MODE_SAT:     next_count = limit;
                MODE_ONESHOT: next_count = limit;
                default:      next_count = ZERO_W;
            endcase
        end else if (!down) begin
            if (up_sum_s <= lim_x_s) begin
                next_count = up_sum_s[WIDTH-1:0];
                term_hit   = (mode == MODE_ONESHOT) && (up_sum_s == lim_x_s);
            end else begin
                case (mode)
                    MODE_WRAP: begin
                        next_count = up_wrap_s;
                        wrap_hit   = 1'b1;
                    end
                    MODE_SAT: begin
                        next_count = limit;
                    end
                    MODE_ONESHOT: begin
                        next_count = limit;
                        term_hit   = 1'b1;
                    end
                    default: begin
                        next_count = up_wrap_s;
                        wrap_hit   = 1'b1;
                    end
                endcase
            end
        end else begin
            if (step_eff <= cnt_x_s) begin
                next_count = dn_diff_s;
                term_hit   = (mode == MODE_ONESHOT) && (step_eff == cnt_x_s);
            end else begin
                case (mode)
                    MODE_WRAP: begin
                        next_count = dn_wrap_s;
                        wrap_hit   = 1'b1;
                    end
                    MODE_SAT: begin
                        next_count = ZERO_W;
                    end
                    MODE_ONESHOT: begin
                        next_count = ZERO_W;
                        term_hit   = 1'b1;
                    end
                    default: begin
                        next_count = dn_wrap_s;
                        wrap_hit   = 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/counter_ud_mod.sv
// Programmable-modulus up/down counter with variable step, synchronous
// load and wrap / saturate / one-shot run modes. Holds the count, wrap
// pulse and one-shot state registers and the load > enable > hold priority.
module counter_ud_mod
    import counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load_en,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              down,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  limit,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_min,
    output logic              wrap,
    output logic              done
);

    logic [WIDTH-1:0] count_r;
    logic             wrap_r;
    cnt_state_e       state_r;

    logic [WIDTH-1:0] count_nxt_s;
    logic             wrap_nxt_s;
    cnt_state_e       state_nxt_s;

    logic [WIDTH:0]   step_x_s;
    logic [WIDTH:0]   lim_x_s;
    logic [WIDTH:0]   step_eff_s;
    logic [WIDTH-1:0] load_clip_s;
    cnt_mode_e        mode_s;

    logic [WIDTH-1:0] step_count_s;
    logic             step_wrap_s;
    logic             step_term_s;

    // A step larger than the whole range is clamped to the limit.
    assign step_x_s    = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign lim_x_s     = {1'b0, limit};
    assign step_eff_s  = (step_x_s < lim_x_s) ? step_x_s : lim_x_s;
    assign load_clip_s = (load_val > limit) ? limit : load_val;
    assign mode_s      = decode_mode(mode);

    counter_ud_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count      (count_r),
        .step_eff   (step_eff_s),
        .limit      (limit),
        .down       (down),
        .mode       (mode_s),
        .next_count (step_count_s),
        .wrap_hit   (step_wrap_s),
        .term_hit   (step_term_s)
    );

    // Next-state logic: load beats enable; DONE freezes the count until a
    // load or a mode change releases it back to RUN.
    always_comb begin
        count_nxt_s = count_r;
        wrap_nxt_s  = 1'b0;
        state_nxt_s = state_r;
        if (load_en) begin
            count_nxt_s = load_clip_s;
            state_nxt_s = ST_RUN;
        end else if (state_r == ST_DONE) begin
            if (mode_s != MODE_ONESHOT) begin
                state_nxt_s = ST_RUN;
            end else begin
                state_nxt_s = ST_DONE;
            end
        end else if (en) begin
            count_nxt_s = step_count_s;
            wrap_nxt_s  = step_wrap_s;
            state_nxt_s = step_term_s ? ST_DONE : ST_RUN;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count, wrap pulse and one-shot state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {WIDTH{1'b0}};
            wrap_r  <= 1'b0;
            state_r <= ST_RUN;
        end else begin
            count_r <= count_nxt_s;
            wrap_r  <= wrap_nxt_s;
            state_r <= state_nxt_s;
        end
    end

    assign count  = count_r;
    assign wrap   = wrap_r;
    assign done   = (state_r == ST_DONE);
    assign at_max = (count_r == limit);
    assign at_min = (count_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_counter_ud_mod.sv
// Directed bench for counter_ud_mod (WIDTH=8, STEP_W=4) with hand-computed
// expected values checked by immediate assertions.
module tb_counter_ud_mod;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load_en;
    logic [7:0] load_val;
    logic       down;
    logic [3:0] step;
    logic [1:0] mode;
    logic [7:0] limit;
    logic [7:0] count;
    logic       at_max;
    logic       at_min;
    logic       wrap;
    logic       done;

    int total;
    int passed;
    int failed;

    counter_ud_mod #(
        .WIDTH  (8),
        .STEP_W (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load_en  (load_en),
        .load_val (load_val),
        .down     (down),
        .step     (step),
        .mode     (mode),
        .limit    (limit),
        .count    (count),
        .at_max   (at_max),
        .at_min   (at_min),
        .wrap     (wrap),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load_en  = 1'b1;
        load_val = v;
        tick();
        load_en  = 1'b0;
    endtask

    initial begin
        total = 0; passed = 0; failed = 0;
        rst = 1'b0; en = 1'b0; load_en = 1'b0; load_val = 8'd0;
        down = 1'b0; step = 4'd0; mode = 2'b00; limit = 8'd0;

        // Reset asserted before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_count", count, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_done", done, 0);
        tick();
        rst = 1'b0;

        // Wrap mode, limit 9, step 3, up: 3,6,9,2(wrap),5
        limit = 8'd9; step = 4'd3; mode = 2'b00; down = 1'b0; en = 1'b1;
        tick(); chk("wu_3", count, 3); chk("wu_3_wrap", wrap, 0);
        tick(); chk("wu_6", count, 6);
        tick(); chk("wu_9", count, 9); chk("wu_9_atmax", at_max, 1);
        tick(); chk("wu_2", count, 2); chk("wu_2_wrap", wrap, 1);
        tick(); chk("wu_5", count, 5); chk("wu_5_wrap", wrap, 0);
        en = 1'b0;

        // Wrap down from 1, step 3, limit 9: 1 + 9 + 1 - 3 = 8
        do_load(8'd1); chk("wd_load", count, 1);
        down = 1'b1; en = 1'b1;
        tick(); chk("wd_8", count, 8); chk("wd_8_wrap", wrap, 1);
        en = 1'b0; down = 1'b0;

        // Step 0 holds
        step = 4'd0; en = 1'b1;
        tick(); chk("step0_hold", count, 8); chk("step0_wrap", wrap, 0);
        en = 1'b0;

        // Saturate, limit 200, step 15: 190 -> 200 -> 200
        mode = 2'b01; limit = 8'd200; step = 4'd15;
        do_load(8'd190); chk("sat_load", count, 190);
        en = 1'b1;
        tick(); chk("sat_200", count, 200); chk("sat_wrap", wrap, 0);
        tick(); chk("sat_hold", count, 200); chk("sat_atmax", at_max, 1);
        chk("sat_wrap2", wrap, 0);
        en = 1'b0;
        do_load(8'd4);
        down = 1'b1; en = 1'b1;
        tick(); chk("sat_dn0", count, 0); chk("sat_atmin", at_min, 1);
        chk("sat_dn_wrap", wrap, 0);
        en = 1'b0; down = 1'b0;

        // One-shot, limit 10, step 4: 4, 8, 10 done, hold
        mode = 2'b10; limit = 8'd10; step = 4'd4;
        do_load(8'd0);
        en = 1'b1;
        tick(); chk("os_4", count, 4); chk("os_4_done", done, 0);
        tick(); chk("os_8", count, 8);
        tick(); chk("os_10", count, 10); chk("os_10_done", done, 1);
        chk("os_10_wrap", wrap, 0);
        tick(); chk("os_hold", count, 10); chk("os_hold_done", done, 1);
        // load beats en and clears done
        load_en = 1'b1; load_val = 8'd2;
        tick(); load_en = 1'b0;
        chk("os_load", count, 2); chk("os_load_done", done, 0);
        // exact landing on limit: 2 -> 6 -> 10 done
        tick(); chk("os_6", count, 6); chk("os_6_done", done, 0);
        tick(); chk("os_exact", count, 10); chk("os_exact_done", done, 1);
        en = 1'b0;

        // Leave DONE by switching to wrap mode, then resume wrapping: 10+4-11 = 3
        mode = 2'b00;
        tick(); chk("mc_done", done, 0); chk("mc_hold", count, 10);
        en = 1'b1;
        tick(); chk("mc_3", count, 3); chk("mc_wrap", wrap, 1);
        en = 1'b0;

        // One-shot down landing exactly on 0
        mode = 2'b10; down = 1'b1;
        do_load(8'd4);
        en = 1'b1;
        tick(); chk("osd_0", count, 0); chk("osd_done", done, 1);
        en = 1'b0; down = 1'b0;

        // Mode 11 behaves as wrap: limit 10, 8 + 4 - 11 = 1
        mode = 2'b11;
        do_load(8'd8);
        en = 1'b1;
        tick(); chk("m11_1", count, 1); chk("m11_wrap", wrap, 1);
        en = 1'b0;

        // Load is clamped to limit
        mode = 2'b00; limit = 8'd100;
        do_load(8'd250); chk("load_clip", count, 100);

        // Step 15 with limit 5 acts as step 5: 0 -> 5 -> (10-6)=4 wrap
        limit = 8'd5; step = 4'd15;
        do_load(8'd0);
        en = 1'b1;
        tick(); chk("clamp_5", count, 5); chk("clamp_5_wrap", wrap, 0);
        tick(); chk("clamp_4", count, 4); chk("clamp_4_wrap", wrap, 1);
        en = 1'b0;

        // Stale count: limit lowered to 50 while count 80
        limit = 8'd100; step = 4'd1;
        do_load(8'd80);
        limit = 8'd50; en = 1'b1;
        tick(); chk("stale_wrap", count, 0); chk("stale_wrap_w", wrap, 0);
        en = 1'b0;
        limit = 8'd100; mode = 2'b01;
        do_load(8'd80);
        limit = 8'd50; en = 1'b1;
        tick(); chk("stale_sat", count, 50);
        en = 1'b0;

        // Asynchronous reset mid-run at count 37
        limit = 8'd100; mode = 2'b00;
        do_load(8'd37); chk("pre_rst", count, 37);
        en = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_wrap", wrap, 0);
        chk("arst_done", done, 0);
        chk("arst_atmin", at_min, 1);
        en = 1'b0;
        tick();
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
